// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory-side responder for the CPU address/data bus.
// Serves CPU reads/writes from mirrored work RAM ($0000-$1FFF) and program ROM
// ($8000-$FFFF). ROM is filled over a valid/ready loader port while the CPU is held.
// Optional feature macro: OPEN_BUS_EN. When defined, unmapped reads leave Data_bus
// unchanged (open bus). When undefined, unmapped reads return 8'h00.
module cpu_bus_responder #(
  parameter int RAM_AW      = 11,
  parameter int ROM_AW      = 15,
  parameter int RELEASE_CYC = 4
) (
  input  logic              clk_ph2,
  input  logic              rst,
  input  logic [15:0]       Addr_bus,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_rw,
  output logic [7:0]        Data_bus,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ROM_AW:0]   ld_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

  localparam logic [ROM_AW:0] COUNT_MAX = {1'b1, {ROM_AW{1'b0}}};
  localparam logic [7:0]      REL_INIT  = 8'(RELEASE_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  logic              hold_nxt;
  logic              ready_nxt;
  logic [ROM_AW-1:0] ld_ptr;
  logic [7:0]        rel_ctr;
  logic [7:0]        rd_data;
  logic              sel_ram;
  logic              sel_rom;
  logic              beat;
  logic              start_ok;

  logic [7:0] ram [2**RAM_AW];
  logic [7:0] rom [2**ROM_AW];

  assign sel_ram  = (Addr_bus[15:13] == 3'b000);
  assign sel_rom  = Addr_bus[15];
  // ld_ready lags the state by a cycle, so acceptance is also qualified by LOAD.
  assign beat     = (state == LOAD) && ld_valid && ld_ready;
  assign start_ok = ((state == IDLE) || (state == RUN)) && ld_start;

  // State register and registered handshake/hold outputs.
  // NOTE: every clocked assignment uses <= so all registers see pre-edge values.
  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cpu_hold <= 1'b1;
      ld_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      cpu_hold <= hold_nxt;
      ld_ready <= ready_nxt;
    end
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ld_start)           state_nxt = LOAD;
      LOAD:    if (beat && ld_last)    state_nxt = RELEASE;
      RELEASE: if (rel_ctr == 8'd0)    state_nxt = RUN;
      RUN:     if (ld_start)           state_nxt = LOAD;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state; registered above, so outputs trail the state by one cycle.
  always_comb begin
    hold_nxt  = (state != RUN);
    ready_nxt = (state == LOAD);
  end

  // Load pointer, byte counter and release countdown.
  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      ld_ptr   <= '0;
      ld_count <= '0;
      rel_ctr  <= 8'd0;
    end else begin
      if (start_ok) begin
        ld_ptr   <= '0;
        ld_count <= '0;
      end else if (beat) begin
        ld_ptr <= ld_ptr + 1'b1;
        if (ld_count != COUNT_MAX) ld_count <= ld_count + 1'b1;
      end
      if (beat && ld_last) begin
        rel_ctr <= REL_INIT;
      end else if ((state == RELEASE) && (rel_ctr != 8'd0)) begin
        rel_ctr <= rel_ctr - 8'd1;
      end
    end
  end

  // ROM fill from the loader port.
  // NOTE: memory arrays have no reset; contents survive rst and start undefined.
  always_ff @(posedge clk_ph2) begin
    if (beat) rom[ld_ptr] <= ld_data;
  end

  // CPU writes to work RAM, blocked while the CPU is held.
  always_ff @(posedge clk_ph2) begin
    if (!cpu_rw && sel_ram && !cpu_hold) ram[Addr_bus[RAM_AW-1:0]] <= cpu_dout;
  end

  // Read mux: RAM mirror, ROM, or zero for unmapped space.
  always_comb begin
    rd_data = 8'h00;
    if (sel_ram)      rd_data = ram[Addr_bus[RAM_AW-1:0]];
    else if (sel_rom) rd_data = rom[Addr_bus[ROM_AW-1:0]];
  end

  // Registered read data; writes leave the bus untouched.
  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      Data_bus <= 8'h00;
    end else if (cpu_rw) begin
`ifdef OPEN_BUS_EN
      if (sel_ram || sel_rom) Data_bus <= rd_data;
`else
      Data_bus <= rd_data;
`endif
    end
  end

endmodule
